// File: rtl/timer_pkg.sv
// Shared constants, write-select encodings and the byte-merge helper for the
// Timer IP count/compare block.
package timer_pkg;

  localparam int CNT_W  = 64;
  localparam int HALF_W = 32;

  typedef enum logic [1:0] {
    SEL_CNT_LO = 2'd0,
    SEL_CNT_HI = 2'd1,
    SEL_CMP_LO = 2'd2,
    SEL_CMP_HI = 2'd3
  } wr_sel_e;

  localparam logic [CNT_W-1:0] CNT_RST = 64'h0000_0000_0000_0000;
  localparam logic [CNT_W-1:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic logic [HALF_W-1:0] merge_bytes(input logic [HALF_W-1:0] old_v,
                                                    input logic [HALF_W-1:0] new_v,
                                                    input logic [3:0]        strb);
    logic [HALF_W-1:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
      else         res[8*b +: 8] = old_v[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/timer_reg64.sv
// 64-bit register with byte-strobed half writes, synchronous clear and increment.
// Priority: half write, then clear, then increment.
module timer_reg64
  import timer_pkg::*;
#(
  parameter logic [CNT_W-1:0] RST_VAL = 64'h0000_0000_0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_lo,
  input  logic              wr_hi,
  input  logic [HALF_W-1:0] wr_data,
  input  logic [3:0]        wr_strb,
  input  logic              clr,
  input  logic              inc,
  output logic [CNT_W-1:0]  q
);

  logic [CNT_W-1:0] q_r;
  logic [CNT_W-1:0] q_nxt_s;

  // next-value selection; a half write suppresses clear and increment for the whole word
  always_comb begin
    q_nxt_s = q_r;
    if (wr_lo) begin
      q_nxt_s[HALF_W-1:0] = merge_bytes(q_r[HALF_W-1:0], wr_data, wr_strb);
    end else if (wr_hi) begin
      q_nxt_s[CNT_W-1:HALF_W] = merge_bytes(q_r[CNT_W-1:HALF_W], wr_data, wr_strb);
    end else if (clr) begin
      q_nxt_s = CNT_RST;
    end else if (inc) begin
      q_nxt_s = q_r + 64'd1;
    end else begin
      q_nxt_s = q_r;
    end
  end

  // value register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_r <= RST_VAL;
    else     q_r <= q_nxt_s;
  end

  assign q = q_r;

endmodule

// File: rtl/timer_counter.sv
// Free-running 64-bit timer count with compare match and sticky interrupt.
// Counts on the divider strobe, freezes under debug halt, clears when disabled.
module timer_counter
  import timer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              timer_en,
  input  logic              cnt_en,
  input  logic              halt_ack,
  input  logic              wr_en,
  input  logic [1:0]        wr_sel,
  input  logic [31:0]       wr_data,
  input  logic [3:0]        wr_strb,
  input  logic              int_en,
  input  logic              int_clr,
  output logic [CNT_W-1:0]  cnt,
  output logic [CNT_W-1:0]  cmp,
  output logic              int_st,
  output logic              tim_int
);

  logic timer_en_r;
  logic int_st_r;
  logic int_st_nxt_s;
  logic wr_act_s;
  logic fall_s;
  logic inc_s;
  logic match_s;
  logic cnt_wr_lo_s;
  logic cnt_wr_hi_s;
  logic cmp_wr_lo_s;
  logic cmp_wr_hi_s;

  // an all-zero strobe is treated as no write at all
  assign wr_act_s = wr_en & (wr_strb != 4'b0000);
  assign fall_s   = timer_en_r & ~timer_en;
  assign inc_s    = timer_en & cnt_en & ~halt_ack;
  assign match_s  = (cnt == cmp);

  // write target decode
  always_comb begin
    cnt_wr_lo_s = 1'b0;
    cnt_wr_hi_s = 1'b0;
    cmp_wr_lo_s = 1'b0;
    cmp_wr_hi_s = 1'b0;
    if (wr_act_s) begin
      case (wr_sel_e'(wr_sel))
        SEL_CNT_LO: cnt_wr_lo_s = 1'b1;
        SEL_CNT_HI: cnt_wr_hi_s = 1'b1;
        SEL_CMP_LO: cmp_wr_lo_s = 1'b1;
        SEL_CMP_HI: cmp_wr_hi_s = 1'b1;
        default:    cnt_wr_lo_s = 1'b0;
      endcase
    end else begin
      cnt_wr_lo_s = 1'b0;
    end
  end

  timer_reg64 #(.RST_VAL(CNT_RST)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .wr_lo   (cnt_wr_lo_s),
    .wr_hi   (cnt_wr_hi_s),
    .wr_data (wr_data),
    .wr_strb (wr_strb),
    .clr     (fall_s),
    .inc     (inc_s),
    .q       (cnt)
  );

  timer_reg64 #(.RST_VAL(CMP_RST)) u_cmp (
    .clk     (clk),
    .rst     (rst),
    .wr_lo   (cmp_wr_lo_s),
    .wr_hi   (cmp_wr_hi_s),
    .wr_data (wr_data),
    .wr_strb (wr_strb),
    .clr     (1'b0),
    .inc     (1'b0),
    .q       (cmp)
  );

  // sticky status: a match outranks a simultaneous clear
  always_comb begin
    if (match_s)      int_st_nxt_s = 1'b1;
    else if (int_clr) int_st_nxt_s = 1'b0;
    else              int_st_nxt_s = int_st_r;
  end

  // enable history and interrupt status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_en_r <= 1'b0;
      int_st_r   <= 1'b0;
    end else begin
      timer_en_r <= timer_en;
      int_st_r   <= int_st_nxt_s;
    end
  end

  assign int_st  = int_st_r;
  assign tim_int = int_st_r & int_en;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed vector table, async reset
// sequence, and randomized traffic against a behavioural model.
module tb_timer_counter;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk;
  logic        rst;
  logic        timer_en;
  logic        cnt_en;
  logic        halt_ack;
  logic        wr_en;
  logic [1:0]  wr_sel;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        int_en;
  logic        int_clr;
  logic [63:0] cnt;
  logic [63:0] cmp;
  logic        int_st;
  logic        tim_int;

  int checks;
  int errors;

  typedef struct {
    logic        ten;
    logic        cen;
    logic        halt;
    logic        wen;
    logic [1:0]  sel;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        ien;
    logic        iclr;
    logic [63:0] ecnt;
    logic [63:0] ecmp;
    logic        eint;
    logic        etim;
  } vec_t;

  vec_t tbl[$];

  // behavioural model state
  logic [63:0] m_cnt;
  logic [63:0] m_cmp;
  logic        m_int;
  logic        m_ten;

  timer_counter dut (
    .clk      (clk),
    .rst      (rst),
    .timer_en (timer_en),
    .cnt_en   (cnt_en),
    .halt_ack (halt_ack),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_data  (wr_data),
    .wr_strb  (wr_strb),
    .int_en   (int_en),
    .int_clr  (int_clr),
    .cnt      (cnt),
    .cmp      (cmp),
    .int_st   (int_st),
    .tim_int  (tim_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic ten, input logic cen, input logic halt, input logic wen,
                     input logic [1:0] sel, input logic [31:0] data, input logic [3:0] strb,
                     input logic ien, input logic iclr, input logic [63:0] ecnt,
                     input logic [63:0] ecmp, input logic eint, input logic etim);
    vec_t v;
    v.ten = ten; v.cen = cen; v.halt = halt; v.wen = wen; v.sel = sel; v.data = data;
    v.strb = strb; v.ien = ien; v.iclr = iclr; v.ecnt = ecnt; v.ecmp = ecmp;
    v.eint = eint; v.etim = etim;
    tbl.push_back(v);
  endtask

  task automatic idle_inputs();
    timer_en = 1'b0; cnt_en = 1'b0; halt_ack = 1'b0; wr_en = 1'b0;
    wr_sel = 2'd0; wr_data = 32'h0; wr_strb = 4'h0; int_en = 1'b0; int_clr = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_cnt = 64'h0; m_cmp = ONES; m_int = 1'b0; m_ten = 1'b0;
  endtask

  function automatic logic [31:0] bytes_merge(input logic [31:0] o, input logic [31:0] n,
                                              input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  // one clock of the reference model from the currently driven inputs
  task automatic model_step();
    logic [63:0] nc;
    logic [63:0] ncmp;
    logic        nint;
    logic        wr;
    nc = m_cnt; ncmp = m_cmp;
    wr = wr_en && (wr_strb != 4'h0);
    if (wr && wr_sel == 2'd0)       nc[31:0]  = bytes_merge(m_cnt[31:0], wr_data, wr_strb);
    else if (wr && wr_sel == 2'd1)  nc[63:32] = bytes_merge(m_cnt[63:32], wr_data, wr_strb);
    else if (m_ten && !timer_en)    nc = 64'h0;
    else if (timer_en && cnt_en && !halt_ack) nc = m_cnt + 64'd1;
    if (wr && wr_sel == 2'd2) ncmp[31:0]  = bytes_merge(m_cmp[31:0], wr_data, wr_strb);
    if (wr && wr_sel == 2'd3) ncmp[63:32] = bytes_merge(m_cmp[63:32], wr_data, wr_strb);
    nint = (m_cnt == m_cmp) ? 1'b1 : (int_clr ? 1'b0 : m_int);
    m_cnt = nc; m_cmp = ncmp; m_int = nint; m_ten = timer_en;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // directed vectors, each applied for one clock then checked
    for (int i = 0; i < 10; i++) add(1, 1, 0, 0, 2'd0, 32'h0, 4'h0, 0, 0, 64'(i + 1), ONES, 0, 0);
    add(1, 1, 0, 1, 2'd0, 32'hFFFF_FFFF, 4'hF, 0, 0, 64'h0000_0000_FFFF_FFFF, ONES, 0, 0);
    add(1, 1, 0, 1, 2'd1, 32'hFFFF_FFFF, 4'hF, 0, 0, ONES, ONES, 0, 0);
    add(1, 1, 0, 0, 2'd0, 32'h0, 4'h0, 0, 0, 64'h0, ONES, 1, 0);
    add(1, 0, 0, 0, 2'd0, 32'h0, 4'h0, 0, 1, 64'h0, ONES, 0, 0);
    add(1, 0, 0, 1, 2'd2, 32'h5, 4'hF, 1, 0, 64'h0, 64'hFFFF_FFFF_0000_0005, 0, 0);
    add(1, 0, 0, 1, 2'd3, 32'h0, 4'hF, 1, 0, 64'h0, 64'h5, 0, 0);
    for (int i = 1; i <= 5; i++) add(1, 1, 0, 0, 2'd0, 32'h0, 4'h0, 1, 0, 64'(i), 64'h5, 0, 0);
    add(1, 1, 1, 0, 2'd0, 32'h0, 4'h0, 1, 0, 64'h5, 64'h5, 1, 1);
    add(1, 1, 1, 0, 2'd0, 32'h0, 4'h0, 1, 1, 64'h5, 64'h5, 1, 1);
    add(1, 0, 1, 1, 2'd0, 32'h3, 4'hF, 1, 0, 64'h3, 64'h5, 1, 1);
    for (int i = 0; i < 4; i++) add(1, 1, 1, 0, 2'd0, 32'h0, 4'h0, 1, 0, 64'h3, 64'h5, 1, 1);
    add(1, 1, 0, 0, 2'd0, 32'h0, 4'h0, 1, 0, 64'h4, 64'h5, 1, 1);
    add(1, 0, 0, 0, 2'd0, 32'h0, 4'h0, 1, 1, 64'h4, 64'h5, 0, 0);
    add(1, 1, 0, 1, 2'd0, 32'hAAAA_0000, 4'hF, 1, 0, 64'hAAAA_0000, 64'h5, 0, 0);
    add(1, 1, 0, 1, 2'd0, 32'h0000_1234, 4'h3, 1, 0, 64'hAAAA_1234, 64'h5, 0, 0);
    add(1, 0, 0, 1, 2'd0, 32'h0, 4'h0, 1, 0, 64'hAAAA_1234, 64'h5, 0, 0);
    add(1, 0, 0, 1, 2'd0, 32'h7, 4'hF, 1, 0, 64'h7, 64'h5, 0, 0);
    add(0, 1, 0, 0, 2'd0, 32'h0, 4'h0, 1, 0, 64'h0, 64'h5, 0, 0);
    add(0, 1, 0, 0, 2'd0, 32'h0, 4'h0, 1, 0, 64'h0, 64'h5, 0, 0);
    add(1, 1, 0, 0, 2'd0, 32'h0, 4'h0, 1, 0, 64'h1, 64'h5, 0, 0);
    add(0, 0, 1, 1, 2'd2, 32'h9, 4'hF, 1, 0, 64'h0, 64'h9, 0, 0);

    do_reset();
    chk("reset_cnt", cnt, 64'h0);
    chk("reset_cmp", cmp, ONES);
    chk("reset_int_st", {63'h0, int_st}, 64'h0);
    chk("reset_tim_int", {63'h0, tim_int}, 64'h0);

    foreach (tbl[i]) begin
      timer_en = tbl[i].ten; cnt_en = tbl[i].cen; halt_ack = tbl[i].halt;
      wr_en = tbl[i].wen; wr_sel = tbl[i].sel; wr_data = tbl[i].data;
      wr_strb = tbl[i].strb; int_en = tbl[i].ien; int_clr = tbl[i].iclr;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_cnt", i), cnt, tbl[i].ecnt);
      chk($sformatf("vec%0d_cmp", i), cmp, tbl[i].ecmp);
      chk($sformatf("vec%0d_int_st", i), {63'h0, int_st}, {63'h0, tbl[i].eint});
      chk($sformatf("vec%0d_tim_int", i), {63'h0, tim_int}, {63'h0, tbl[i].etim});
    end

    // asynchronous reset in the middle of a count, checked before the next edge
    idle_inputs();
    timer_en = 1'b1; cnt_en = 1'b1; int_en = 1'b1;
    wr_en = 1'b1; wr_sel = 2'd2; wr_data = 32'h3; wr_strb = 4'hF;
    @(posedge clk);
    #1 wr_en = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("pre_rst_int_st", {63'h0, int_st}, 64'h1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_rst_cnt", cnt, 64'h0);
    chk("async_rst_cmp", cmp, ONES);
    chk("async_rst_int_st", {63'h0, int_st}, 64'h0);
    chk("async_rst_tim_int", {63'h0, tim_int}, 64'h0);

    // randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 800; c++) begin
      timer_en = ($urandom_range(0, 15) != 0);
      cnt_en   = ($urandom_range(0, 3) != 0);
      halt_ack = ($urandom_range(0, 4) == 0);
      int_en   = $urandom_range(0, 1) == 1;
      int_clr  = ($urandom_range(0, 7) == 0);
      wr_en    = ($urandom_range(0, 3) == 0);
      wr_sel   = 2'($urandom_range(0, 3));
      wr_strb  = 4'($urandom_range(1, 15));
      case (wr_sel)
        2'd2:    wr_data = m_cnt[31:0] + 32'($urandom_range(1, 4));
        2'd3:    wr_data = ($urandom_range(0, 1) == 1) ? m_cnt[63:32] : $urandom;
        2'd1:    wr_data = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom;
        default: wr_data = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFE : $urandom;
      endcase
      model_step();
      @(posedge clk);
      #1;
      chk("rnd_cnt", cnt, m_cnt);
      chk("rnd_cmp", cmp, m_cmp);
      chk("rnd_int_st", {63'h0, int_st}, {63'h0, m_int});
      chk("rnd_tim_int", {63'h0, tim_int}, {63'h0, m_int & int_en});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
